updown_cntr_n: RTL and testbench

Parametrised loadable up/down counter with a programmable modulus, step size and wrap/saturate overflow handling. It is the general-purpose successor to the fixed 8-bit loadable up/down counter. It generalises width, terminal value and step. It adds an enable, an overflow flag and an optional saturating mode. It sits in datapath and control blocks wherever a bounded, loadable event or address counter is needed. It exposes its control state for debug and for downstream sequencing.

---
 rtl/updown_cntr_n.sv | 100 ++++++++++
 tb/tb_updown_cntr_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_cntr_n.sv
// Loadable up/down counter with modulus LIMIT+1, step STEP and wrap/saturate overflow.
// Define CNTR_SAT_EN to add the sat port and build the saturating path; otherwise it always wraps.
module updown_cntr_n #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = '1,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
`ifdef CNTR_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             ovf
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_DEC  = 3'b011
    } state_t;

    localparam logic [WIDTH:0] LIMIT_X = {1'b0, LIMIT};
    localparam logic [WIDTH:0] STEP_X  = {1'b0, STEP};
    localparam logic [WIDTH:0] MOD_X   = LIMIT_X + (WIDTH+1)'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             sat_mode;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   wrap_up;
    logic [WIDTH:0]   wrap_dn;

`ifdef CNTR_SAT_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    // Sums are one bit wider so LIMIT+1 = 2**WIDTH never truncates before the wrap.
    assign sum_up  = {1'b0, d_out} + STEP_X;
    assign wrap_up = sum_up - MOD_X;
    assign wrap_dn = {1'b0, d_out} + MOD_X - STEP_X;

    always_comb begin
        state_nxt = ST_IDLE;
        count_nxt = d_out;
        ovf_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD, ST_INC, ST_DEC: begin
                if (load) begin
                    state_nxt = ST_LOAD;
                    count_nxt = (d_in > LIMIT) ? LIMIT : d_in;
                end else if (en && inc) begin
                    state_nxt = ST_INC;
                    if (sum_up <= LIMIT_X) begin
                        count_nxt = sum_up[WIDTH-1:0];
                    end else begin
                        ovf_nxt   = 1'b1;
                        count_nxt = sat_mode ? LIMIT : wrap_up[WIDTH-1:0];
                    end
                end else if (en) begin
                    state_nxt = ST_DEC;
                    if (d_out >= STEP) begin
                        count_nxt = d_out - STEP;
                    end else begin
                        ovf_nxt   = 1'b1;
                        count_nxt = sat_mode ? '0 : wrap_dn[WIDTH-1:0];
                    end
                end
            end
            // An unused code recovers to IDLE and leaves the count alone.
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            d_out <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            d_out <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_updown_cntr_n.sv
// Directed bench for updown_cntr_n: three parameterisations share one stimulus bus.
module tb_updown_cntr_n;

    logic       clk = 1'b0;
    logic       reset, en, load, inc;
    logic [7:0] d_in;
`ifdef CNTR_SAT_EN
    logic       sat;
`endif

    logic [7:0] d_out_a, d_out_b, d_out_c;
    logic [2:0] st_a, st_b, st_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // a: defaults (LIMIT=255, STEP=1); b: LIMIT=9, STEP=3; c: LIMIT=9, STEP=1
    updown_cntr_n u_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc),
`ifdef CNTR_SAT_EN
        .sat(sat),
`endif
        .d_in(d_in), .d_out(d_out_a), .o_state(st_a), .ovf(ovf_a)
    );

    updown_cntr_n #(.WIDTH(8), .LIMIT(8'd9), .STEP(8'd3)) u_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc),
`ifdef CNTR_SAT_EN
        .sat(sat),
`endif
        .d_in(d_in), .d_out(d_out_b), .o_state(st_b), .ovf(ovf_b)
    );

    updown_cntr_n #(.WIDTH(8), .LIMIT(8'd9), .STEP(8'd1)) u_c (
        .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc),
`ifdef CNTR_SAT_EN
        .sat(sat),
`endif
        .d_in(d_in), .d_out(d_out_c), .o_state(st_c), .ovf(ovf_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic e, input logic i, input logic [7:0] d);
        load = l;
        en   = e;
        inc  = i;
        d_in = d;
    endtask

    task automatic test_reset();
        int exp_d[4]  = '{1, 2, 0, 1};
        int exp_s[4]  = '{2, 2, 0, 2};
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({d_out_a, st_a, ovf_a} !== {8'd0, 3'b000, 1'b0}) begin
                n_err++;
                $display("FAIL reset[%0d]: d_out=%0d o_state=%b ovf=%b, expected 0 000 0",
                         i, d_out_a, st_a, ovf_a);
            end
        end
        // Release and count twice, then reset mid-count and resume.
        for (int i = 0; i < 4; i++) begin
            reset = (i == 2);
            drive(1'b0, 1'b1, 1'b1, 8'h00);
            tick();
            n_cmp++;
            if ({d_out_a, st_a, ovf_a} !== {8'(exp_d[i]), 3'(exp_s[i]), 1'b0}) begin
                n_err++;
                $display("FAIL reset_resume[%0d]: d_out=%0d o_state=%b ovf=%b, expected %0d %b 0",
                         i, d_out_a, st_a, ovf_a, exp_d[i], 3'(exp_s[i]));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        int   exp_d[6] = '{8, 1, 4, 7, 0, 3};
        logic exp_o[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 8'd8);
            else        drive(1'b0, 1'b1, 1'b1, 8'd0);
            tick();
            n_cmp++;
            if ({d_out_b, st_b, ovf_b} !== {8'(exp_d[i]), (i == 0) ? 3'b001 : 3'b010, exp_o[i]}) begin
                n_err++;
                $display("FAIL wrap_up[%0d]: d_out=%0d o_state=%b ovf=%b, expected %0d ovf=%b",
                         i, d_out_b, st_b, ovf_b, exp_d[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        int   exp_d[4] = '{1, 0, 9, 8};
        logic exp_o[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 8'd1);
            else        drive(1'b0, 1'b1, 1'b0, 8'd0);
            tick();
            n_cmp++;
            if ({d_out_c, st_c, ovf_c} !== {8'(exp_d[i]), (i == 0) ? 3'b001 : 3'b011, exp_o[i]}) begin
                n_err++;
                $display("FAIL wrap_down[%0d]: d_out=%0d o_state=%b ovf=%b, expected %0d ovf=%b",
                         i, d_out_c, st_c, ovf_c, exp_d[i], exp_o[i]);
            end
        end
    endtask

    // STEP=3 down across zero: 3 -> 0 is exact, then 0 -> 7 wraps.
    task automatic test_step_boundary();
        int   exp_d[3] = '{3, 0, 7};
        logic exp_o[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 8'd3);
            else        drive(1'b0, 1'b1, 1'b0, 8'd0);
            tick();
            n_cmp++;
            if ({d_out_b, ovf_b} !== {8'(exp_d[i]), exp_o[i]}) begin
                n_err++;
                $display("FAIL step_boundary[%0d]: d_out=%0d ovf=%b, expected %0d ovf=%b",
                         i, d_out_b, ovf_b, exp_d[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_full_range_wrap();
        int   exp_d[3] = '{255, 0, 255};
        logic exp_o[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 8'd255);
            else if (i == 1) drive(1'b0, 1'b1, 1'b1, 8'd0);
            else             drive(1'b0, 1'b1, 1'b0, 8'd0);
            tick();
            n_cmp++;
            if ({d_out_a, ovf_a} !== {8'(exp_d[i]), exp_o[i]}) begin
                n_err++;
                $display("FAIL full_range[%0d]: d_out=%0d ovf=%b, expected %0d ovf=%b",
                         i, d_out_a, ovf_a, exp_d[i], exp_o[i]);
            end
        end
    endtask

`ifdef CNTR_SAT_EN
    task automatic test_saturate();
        int   exp_d[7] = '{254, 255, 255, 255, 1, 0, 0};
        logic exp_o[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        sat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 8'd254);
            else if (i < 4)  drive(1'b0, 1'b1, 1'b1, 8'd0);
            else if (i == 4) drive(1'b1, 1'b0, 1'b0, 8'd1);
            else             drive(1'b0, 1'b1, 1'b0, 8'd0);
            tick();
            n_cmp++;
            if ({d_out_a, ovf_a} !== {8'(exp_d[i]), exp_o[i]}) begin
                n_err++;
                $display("FAIL saturate[%0d]: d_out=%0d ovf=%b, expected %0d ovf=%b",
                         i, d_out_a, ovf_a, exp_d[i], exp_o[i]);
            end
        end
        sat = 1'b0;
    endtask
`endif

    task automatic test_priority_clamp();
        drive(1'b1, 1'b1, 1'b1, 8'd200);
        tick();
        n_cmp++;
        if ({d_out_c, st_c, ovf_c} !== {8'd9, 3'b001, 1'b0}) begin
            n_err++;
            $display("FAIL priority_clamp: d_out=%0d o_state=%b ovf=%b, expected 9 001 0",
                     d_out_c, st_c, ovf_c);
        end
        drive(1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        n_cmp++;
        if ({d_out_c, st_c, ovf_c} !== {8'd9, 3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL priority_hold: d_out=%0d o_state=%b ovf=%b, expected 9 000 0",
                     d_out_c, st_c, ovf_c);
        end
    endtask

    task automatic test_direction();
        int exp_d[5] = '{5, 6, 5, 6, 5};
        int exp_s[5] = '{1, 2, 3, 2, 3};
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 8'd5);
            else        drive(1'b0, 1'b1, logic'(i % 2), 8'd0);
            tick();
            n_cmp++;
            if ({d_out_c, st_c, ovf_c} !== {8'(exp_d[i]), 3'(exp_s[i]), 1'b0}) begin
                n_err++;
                $display("FAIL direction[%0d]: d_out=%0d o_state=%b ovf=%b, expected %0d %b 0",
                         i, d_out_c, st_c, ovf_c, exp_d[i], 3'(exp_s[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[4] = '{8'd10, 8'd20, 8'd30, 8'd4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, vals[i]);
            tick();
            n_cmp++;
            if ({d_out_a, st_a, d_out_c} !== {vals[i], 3'b001, (vals[i] > 8'd9) ? 8'd9 : vals[i]}) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: a=%0d o_state=%b c=%0d, expected load of %0d",
                         i, d_out_a, st_a, d_out_c, vals[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
`ifdef CNTR_SAT_EN
        sat = 1'b0;
`endif
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_step_boundary();
        test_full_range_wrap();
`ifdef CNTR_SAT_EN
        test_saturate();
`endif
        test_priority_clamp();
        test_direction();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
